// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//   Watches a multiplexed 7-segment display bus and recovers the hex value
//   shown on each digit. A {an_i, seg_i} pattern must stay unchanged for
//   STABLE_CYCLES cycles before it is captured, which filters scan glitches.
//   Each display dwell is captured at most once. Illegal segment patterns set
//   a sticky error. frame_o pulses once after every digit has been captured.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   seg_i          segment lines {A..G}, A = bit 6, active high
//   an_i           one-hot digit select, bit k = digit k
//   clear_i        drops captured/valid/blank/error state (digits_o kept)
//   digits_o       decoded nibble per digit, digit k at [4k+3:4k]
//   digit_valid_o  digit k holds a decoded hex value
//   blank_o        digit k was last captured as blank
//   frame_o        one-cycle pulse when all digits have been captured
//   err_o          sticky illegal-pattern flag
//   err_digit_o    digit index of the first illegal capture
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int   NUM_DIGITS    = 4,
  parameter int   STABLE_CYCLES = 4,
  localparam int  DW            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   an_i,
  input  logic                    clear_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   digit_valid_o,
  output logic [NUM_DIGITS-1:0]   blank_o,
  output logic                    frame_o,
  output logic                    err_o,
  output logic [DW-1:0]           err_digit_o
);

  localparam int             CW         = $clog2(STABLE_CYCLES + 1);
  localparam int             SW         = NUM_DIGITS + 7;
  localparam logic [CW-1:0]  STABLE_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  typedef enum logic [1:0] {SEG_HEX, SEG_BLANK, SEG_ILLEGAL} seg_class_t;

  typedef struct packed {
    seg_class_t cls;
    logic [3:0] value;
  } decode_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n, cnt_inc;
  logic [SW-1:0]           prev_sample;
  logic [NUM_DIGITS-1:0]   mask, mask_n;
  logic [DW-1:0]           an_idx;
  logic                    an_onehot;
  logic                    changed;
  logic                    capture_go;
  decode_t                 dec;

  assign an_onehot = $onehot(an_i);
  assign changed   = ({an_i, seg_i} != prev_sample);
  assign cnt_inc   = (cnt == STABLE_MAX) ? cnt : cnt + CW'(1);
  assign mask_n    = mask | an_i;

  // Exact-match segment decode; anything outside the table is illegal.
  always_comb begin
    dec = '{cls: SEG_HEX, value: 4'h0};
    unique case (seg_i)
      7'h7E: dec.value = 4'h0;
      7'h30: dec.value = 4'h1;
      7'h6D: dec.value = 4'h2;
      7'h79: dec.value = 4'h3;
      7'h33: dec.value = 4'h4;
      7'h5B: dec.value = 4'h5;
      7'h5F: dec.value = 4'h6;
      7'h70: dec.value = 4'h7;
      7'h7F: dec.value = 4'h8;
      7'h7B: dec.value = 4'h9;
      7'h77: dec.value = 4'hA;
      7'h1F: dec.value = 4'hB;
      7'h4E: dec.value = 4'hC;
      7'h3D: dec.value = 4'hD;
      7'h4F: dec.value = 4'hE;
      7'h47: dec.value = 4'hF;
      7'h00: dec.cls   = SEG_BLANK;
      default: dec.cls = SEG_ILLEGAL;
    endcase
  end

  always_comb begin
    an_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (an_i[k]) an_idx = DW'(k);
    end
  end

  // Next-state logic. A capture happens on the cycle the run of identical
  // samples reaches STABLE_CYCLES; HELD blocks a second capture of the same
  // dwell until the bus changes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_n    = state;
    cnt_n      = cnt;
    capture_go = 1'b0;
    if (!an_onehot) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == HELD && !changed) begin
      cnt_n = cnt_inc;
    end else begin
      cnt_n = changed ? CW'(1) : cnt_inc;
      if (cnt_n == STABLE_MAX) begin
        capture_go = 1'b1;
        state_n    = HELD;
      end else begin
        state_n = SETTLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the digit store is reset as well because its contents drive
      // digits_o directly and must read zero after reset.
      state         <= IDLE;
      cnt           <= '0;
      prev_sample   <= '0;
      mask          <= '0;
      digits_o      <= '0;
      digit_valid_o <= '0;
      blank_o       <= '0;
      frame_o       <= 1'b0;
      err_o         <= 1'b0;
      err_digit_o   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      prev_sample <= {an_i, seg_i};
      frame_o     <= 1'b0;
      if (clear_i) begin
        // Clear wins over a same-cycle capture; the FSM still moves to HELD
        // so the discarded dwell is not captured later.
        mask          <= '0;
        digit_valid_o <= '0;
        blank_o       <= '0;
        err_o         <= 1'b0;
        err_digit_o   <= '0;
      end else if (capture_go) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (an_i[k]) begin
            digit_valid_o[k] <= (dec.cls == SEG_HEX);
            blank_o[k]       <= (dec.cls == SEG_BLANK);
            if (dec.cls == SEG_HEX) digits_o[4*k +: 4] <= dec.value;
          end
        end
        if (dec.cls == SEG_ILLEGAL && !err_o) begin
          err_o       <= 1'b1;
          err_digit_o <= an_idx;
        end
        // The completing capture starts an empty mask for the next frame.
        if (mask_n == '1) begin
          mask    <= '0;
          frame_o <= 1'b1;
        end else begin
          mask <= mask_n;
        end
      end
    end
  end

endmodule
